pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-PC controller for the single-threaded pipelined CPU. It drives the program counter's newAddress and PCWrite inputs.
- Arbitrates between five sources: sequential fetch, ID-stage jumps, EX-stage taken branches, exception entry and exception return.
- Latches redirects that arrive while instruction memory is busy, and tracks handler mode and the EPC.
- Generates the IF and ID flush strobes for the pipeline registers.

Parameters:
- RESET_VECTOR, 32'h0000_0000, NewAddress value driven during and straight after reset.
- EXC_VECTOR, 32'h0000_0080, exception handler entry address.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- CurrentPC  in  32  present PC register value.
- ImemReady  in  1  instruction memory can accept a new fetch address this cycle.
- Stall  in  1  load-use hazard from the hazard unit; freezes the PC.
- Jump  in  1  jump resolved in ID.
- JumpTarget  in  32  jump destination.
- BranchTaken  in  1  taken branch resolved in EX.
- BranchTarget  in  32  branch destination.
- Exception  in  1  exception raised by the instruction in EX.
- ExcPC  in  32  PC of the faulting instruction.
- Eret  in  1  exception-return instruction in EX.
- NewAddress  out  32  next PC value (to the PC register).
- PCWrite  out  1  PC update enable.
- FlushIF  out  1  squash the IF/ID register.
- FlushID  out  1  squash the ID/EX register.
- EPC  out  32  saved exception PC (registered).
- InHandler  out  1  handler mode flag (registered).
- Holding  out  1  a redirect is pending (registered).

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high.
- Reset values: Holding=0, InHandler=0, EPC=0, pending target=RESET_VECTOR.
- While Reset=1: NewAddress=RESET_VECTOR, PCWrite=0, FlushIF=1, FlushID=1.
- State is {InHandler, Holding}.
  - Holding: FSM with two states, RUN (Holding=0) and HOLD (Holding=1).
  - InHandler: independent flag.
- Redirect request in a cycle, by priority:
  1. Exception, only when InHandler=0. Target=EXC_VECTOR. Exception while InHandler=1 is ignored.
  2. Eret, only when InHandler=1. Target=EPC. Eret while InHandler=0 is ignored.
  3. BranchTaken. Target=BranchTarget.
  4. Jump. Target=JumpTarget.
- Output paths are combinational, so there is zero added latency: a redirect in cycle n with ImemReady=1 puts the target in the PC after edge n.
- RUN state:
  - Redirect and ImemReady=1: NewAddress=target, PCWrite=1. Stay in RUN.
  - Redirect and ImemReady=0: latch target as pending, PCWrite=0, go to HOLD.
  - No redirect, Stall=0, ImemReady=1: NewAddress=CurrentPC+PC_STEP, PCWrite=1. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - No redirect and (Stall=1 or ImemReady=0): PCWrite=0, NewAddress=CurrentPC.
- HOLD state:
  - NewAddress=pending, PCWrite=ImemReady. Go to RUN on the edge where ImemReady=1.
  - A new redirect in HOLD replaces pending. Exception and Eret always replace it.
  - A branch or jump does not replace a pending exception or Eret target; pending_is_exc is kept internally for this.
  - If the new redirect arrives in the same cycle as ImemReady=1, the new target is written to the PC directly.
  - Stall is ignored in HOLD.
- Redirects always override Stall.
- Flush outputs:
  - FlushIF=1 in any cycle with an accepted redirect, and in every HOLD cycle.
  - FlushID=1 in cycles with an accepted Exception, Eret or BranchTaken. Jump does not assert FlushID.
- EPC and InHandler:
  - Accepted Exception: EPC<=ExcPC and InHandler<=1 on that edge, regardless of ImemReady.
  - Accepted Eret: InHandler<=0 on that edge.
- Reset mid-HOLD or mid-handler discards the pending target and EPC immediately.

Test Plan:
1. Reset release, CurrentPC=0, ImemReady=1, no requests -> NewAddress=4, PCWrite=1 every cycle; PC steps 0,4,8,C.
2. CurrentPC=0x40, Stall=1 for 2 cycles -> PCWrite=0, FlushIF=0 for both; then NewAddress=0x44.
3. CurrentPC=0x20, Jump=1 (JumpTarget=0x100) and BranchTaken=1 (BranchTarget=0x200) in the same cycle, with Stall=1 -> NewAddress=0x200, PCWrite=1, FlushIF=1, FlushID=1.
4. ImemReady=0, BranchTaken to 0x300 -> Holding=1, PCWrite=0. Next cycle Exception with ExcPC=0x5C -> pending=0x80, EPC=0x5C. ImemReady=1 two cycles later -> PC=0x80, Holding=0, InHandler=1.
5. InHandler=1, EPC=0x5C, Exception=1 -> ignored, EPC unchanged. Then Eret -> NewAddress=0x5C, FlushIF=FlushID=1, InHandler=0.
6. Reset pulsed during HOLD (pending 0x300) -> Holding=0, NewAddress=RESET_VECTOR; after release, fetch resumes sequentially.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates sequential fetch, ID jumps, EX branches,
// exception entry and exception return. It parks redirects that arrive while
// instruction memory is busy, and tracks handler mode and the saved EPC.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] CurrentPC,
  input  logic        ImemReady,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Exception,
  input  logic [31:0] ExcPC,
  input  logic        Eret,
  output logic [31:0] NewAddress,
  output logic        PCWrite,
  output logic        FlushIF,
  output logic        FlushID,
  output logic [31:0] EPC,
  output logic        InHandler,
  output logic        Holding
);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e      state_q, state_d;
  logic        in_handler_q, in_handler_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pending_q, pending_d;
  logic        pending_is_exc_q, pending_is_exc_d;

  logic        exc_acc, eret_acc, priv_req, redirect, flush_id_req, take;
  logic [31:0] target;
  logic [31:0] new_address;
  logic        pc_write, flush_if, flush_id;

  // Qualify the four redirect sources and pick the highest-priority target.
  always_comb begin
    exc_acc      = Exception & ~in_handler_q;
    eret_acc     = Eret & in_handler_q;
    priv_req     = exc_acc | eret_acc;
    redirect     = priv_req | BranchTaken | Jump;
    flush_id_req = priv_req | BranchTaken;
    if (exc_acc) begin
      target = EXC_VECTOR;
    end else if (eret_acc) begin
      target = epc_q;
    end else if (BranchTaken) begin
      target = BranchTarget;
    end else begin
      target = JumpTarget;
    end
    // In HOLD a plain branch/jump must not displace a parked exception/eret target.
    if (state_q == StRun) begin
      take = redirect;
    end else begin
      take = priv_req | (redirect & ~pending_is_exc_q);
    end
  end

  // Next-state and next-PC selection for the RUN/HOLD machine and handler state.
  always_comb begin
    state_d          = state_q;
    pending_d        = pending_q;
    pending_is_exc_d = pending_is_exc_q;
    epc_d            = epc_q;
    in_handler_d     = in_handler_q;
    new_address      = CurrentPC;
    pc_write         = 1'b0;
    flush_if         = 1'b0;
    flush_id         = 1'b0;
    unique case (state_q)
      StRun: begin
        if (redirect) begin
          new_address = target;
          pc_write    = ImemReady;
          flush_if    = 1'b1;
          flush_id    = flush_id_req;
          if (!ImemReady) begin
            state_d          = StHold;
            pending_d        = target;
            pending_is_exc_d = priv_req;
          end
        end else if (!Stall && ImemReady) begin
          new_address = CurrentPC + PC_STEP;
          pc_write    = 1'b1;
        end
      end
      StHold: begin
        new_address = take ? target : pending_q;
        pc_write    = ImemReady;
        flush_if    = 1'b1;
        flush_id    = take & flush_id_req;
        if (take) begin
          pending_d        = target;
          pending_is_exc_d = priv_req;
        end
        if (ImemReady) begin
          state_d = StRun;
        end
      end
    endcase
    // Handler bookkeeping happens on acceptance, independent of ImemReady.
    if (exc_acc) begin
      epc_d        = ExcPC;
      in_handler_d = 1'b1;
    end else if (eret_acc) begin
      in_handler_d = 1'b0;
    end
  end

  // State registers; reset throws away any parked redirect and the EPC.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q          <= StRun;
      in_handler_q     <= 1'b0;
      epc_q            <= 32'h0;
      pending_q        <= RESET_VECTOR;
      pending_is_exc_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      in_handler_q     <= in_handler_d;
      epc_q            <= epc_d;
      pending_q        <= pending_d;
      pending_is_exc_q <= pending_is_exc_d;
    end
  end

  assign NewAddress = Reset ? RESET_VECTOR : new_address;
  assign PCWrite    = Reset ? 1'b0 : pc_write;
  assign FlushIF    = Reset ? 1'b1 : flush_if;
  assign FlushID    = Reset ? 1'b1 : flush_id;
  assign EPC        = epc_q;
  assign InHandler  = in_handler_q;
  assign Holding    = (state_q == StHold);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, a reset-during-HOLD sequence,
// then randomized traffic against a priority-list reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0080;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] CurrentPC, JumpTarget, BranchTarget, ExcPC;
  logic        ImemReady, Stall, Jump, BranchTaken, Exception, Eret;
  logic [31:0] NewAddress, EPC;
  logic        PCWrite, FlushIF, FlushID, InHandler, Holding;

  int n_pass = 0;
  int n_chk  = 0;

  pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .CurrentPC(CurrentPC), .ImemReady(ImemReady),
    .Stall(Stall), .Jump(Jump), .JumpTarget(JumpTarget), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Exception(Exception), .ExcPC(ExcPC), .Eret(Eret),
    .NewAddress(NewAddress), .PCWrite(PCWrite), .FlushIF(FlushIF), .FlushID(FlushID),
    .EPC(EPC), .InHandler(InHandler), .Holding(Holding)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;  logic rdy; logic stall; logic jmp; logic [31:0] jt;
    logic br; logic [31:0] bt; logic exc; logic [31:0] xpc; logic eret;
    logic [31:0] na;  logic pcw; logic fif; logic fid; logic hold; logic inh;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic [31:0] pc, input logic rdy, stall, jmp,
                              input logic [31:0] jt, input logic br, input logic [31:0] bt,
                              input logic exc, input logic [31:0] xpc, input logic eret,
                              input logic [31:0] na, input logic pcw, fif, fid, hold, inh,
                              input logic [31:0] epc);
    vec_t v;
    v.pc = pc; v.rdy = rdy; v.stall = stall; v.jmp = jmp; v.jt = jt; v.br = br; v.bt = bt;
    v.exc = exc; v.xpc = xpc; v.eret = eret; v.na = na; v.pcw = pcw; v.fif = fif;
    v.fid = fid; v.hold = hold; v.inh = inh; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [31:0] pc, input logic rdy, stall, jmp,
                       input logic [31:0] jt, input logic br, input logic [31:0] bt,
                       input logic exc, input logic [31:0] xpc, input logic eret);
    CurrentPC = pc; ImemReady = rdy; Stall = stall; Jump = jmp; JumpTarget = jt;
    BranchTaken = br; BranchTarget = bt; Exception = exc; ExcPC = xpc; Eret = eret;
  endtask

  task automatic check_all(input string tag, input logic [31:0] na, input logic pcw, fif,
                           fid, hold, inh, input logic [31:0] epc);
    chk({tag, ".NewAddress"}, NewAddress, na);
    chk({tag, ".PCWrite"}, {31'b0, PCWrite}, {31'b0, pcw});
    chk({tag, ".FlushIF"}, {31'b0, FlushIF}, {31'b0, fif});
    chk({tag, ".FlushID"}, {31'b0, FlushID}, {31'b0, fid});
    chk({tag, ".Holding"}, {31'b0, Holding}, {31'b0, hold});
    chk({tag, ".InHandler"}, {31'b0, InHandler}, {31'b0, inh});
    chk({tag, ".EPC"}, EPC, epc);
  endtask

  // Reference model state and per-cycle expectations.
  logic [31:0] m_epc, m_pend, n_epc, n_pend, e_na, cur_pc;
  logic        m_hold, m_inh, m_pexc, n_hold, n_inh, n_pexc, e_pcw, e_fif, e_fid;

  task automatic model_reset();
    m_hold = 0; m_inh = 0; m_epc = 0; m_pend = RV; m_pexc = 0;
  endtask

  task automatic model_eval();
    logic        v[4];
    logic [31:0] t[4];
    int          win;
    logic        acc;
    if (Reset) model_reset();
    n_hold = m_hold; n_inh = m_inh; n_epc = m_epc; n_pend = m_pend; n_pexc = m_pexc;
    if (Reset) begin
      e_na = RV; e_pcw = 0; e_fif = 1; e_fid = 1;
      return;
    end
    // Sources in priority order: exception, eret, branch, jump.
    v[0] = Exception && !m_inh; t[0] = EV;
    v[1] = Eret && m_inh;       t[1] = m_epc;
    v[2] = BranchTaken;         t[2] = BranchTarget;
    v[3] = Jump;                t[3] = JumpTarget;
    win = -1;
    for (int k = 3; k >= 0; k--) if (v[k]) win = k;
    e_fif = 0; e_fid = 0; e_pcw = 0; e_na = CurrentPC;
    if (!m_hold) begin
      if (win >= 0) begin
        e_na = t[win]; e_pcw = ImemReady; e_fif = 1; e_fid = (win < 3);
        if (!ImemReady) begin n_hold = 1; n_pend = t[win]; n_pexc = (win < 2); end
      end else if (!Stall && ImemReady) begin
        e_na = CurrentPC + 32'd4; e_pcw = 1;
      end
    end else begin
      acc = (win >= 0) && (win < 2 || !m_pexc);
      e_na = acc ? t[win] : m_pend; e_pcw = ImemReady; e_fif = 1; e_fid = acc && (win < 3);
      if (acc) begin n_pend = t[win]; n_pexc = (win < 2); end
      if (ImemReady) n_hold = 0;
    end
    if (win == 0) begin n_epc = ExcPC; n_inh = 1; end
    else if (win == 1) n_inh = 0;
  endtask

  initial begin
    // Directed rows: one cycle each, state carries from row to row.
    vecs[0]  = mk(32'h0,   1,0,0,0,0,0,0,0,0,              32'h4,  1,0,0,0,0,32'h0);
    vecs[1]  = mk(32'h4,   1,0,0,0,0,0,0,0,0,              32'h8,  1,0,0,0,0,32'h0);
    vecs[2]  = mk(32'h8,   1,0,0,0,0,0,0,0,0,              32'hC,  1,0,0,0,0,32'h0);
    vecs[3]  = mk(32'hC,   1,0,0,0,0,0,0,0,0,              32'h10, 1,0,0,0,0,32'h0);
    vecs[4]  = mk(32'h40,  1,1,0,0,0,0,0,0,0,              32'h40, 0,0,0,0,0,32'h0);
    vecs[5]  = mk(32'h40,  1,1,0,0,0,0,0,0,0,              32'h40, 0,0,0,0,0,32'h0);
    vecs[6]  = mk(32'h40,  1,0,0,0,0,0,0,0,0,              32'h44, 1,0,0,0,0,32'h0);
    vecs[7]  = mk(32'h20,  1,1,1,32'h100,1,32'h200,0,0,0,  32'h200,1,1,1,0,0,32'h0);
    vecs[8]  = mk(32'h200, 0,0,0,0,1,32'h300,0,0,0,        32'h300,0,1,1,0,0,32'h0);
    vecs[9]  = mk(32'h200, 0,0,0,0,0,0,1,32'h5C,0,         32'h80, 0,1,1,1,0,32'h0);
    vecs[10] = mk(32'h200, 0,0,0,0,0,0,0,0,0,              32'h80, 0,1,0,1,1,32'h5C);
    vecs[11] = mk(32'h200, 1,0,0,0,0,0,0,0,0,              32'h80, 1,1,0,1,1,32'h5C);
    vecs[12] = mk(32'h80,  1,0,0,0,0,0,0,0,0,              32'h84, 1,0,0,0,1,32'h5C);
    vecs[13] = mk(32'h84,  1,0,0,0,0,0,1,32'h1234,0,       32'h88, 1,0,0,0,1,32'h5C);
    vecs[14] = mk(32'h88,  1,0,0,0,0,0,0,0,1,              32'h5C, 1,1,1,0,1,32'h5C);
    vecs[15] = mk(32'h5C,  1,0,0,0,0,0,0,0,0,              32'h60, 1,0,0,0,0,32'h5C);
    vecs[16] = mk(32'hFFFF_FFFC,1,0,0,0,0,0,0,0,0,         32'h0,  1,0,0,0,0,32'h5C);
    vecs[17] = mk(32'h100, 1,0,0,0,0,0,0,0,1,              32'h104,1,0,0,0,0,32'h5C);
    vecs[18] = mk(32'h104, 1,0,1,32'h400,0,0,0,0,0,        32'h400,1,1,0,0,0,32'h5C);
    vecs[19] = mk(32'h400, 0,0,0,0,0,0,1,32'h400,0,        32'h80, 0,1,1,0,0,32'h5C);
    vecs[20] = mk(32'h400, 0,0,0,0,1,32'h700,0,0,0,        32'h80, 0,1,0,1,1,32'h400);
    vecs[21] = mk(32'h400, 1,0,1,32'h900,0,0,0,0,0,        32'h80, 1,1,0,1,1,32'h400);
    vecs[22] = mk(32'h80,  1,0,0,0,0,0,0,0,1,              32'h400,1,1,1,0,1,32'h400);
    vecs[23] = mk(32'h400, 1,0,0,0,0,0,0,0,0,              32'h404,1,0,0,0,0,32'h400);
    vecs[24] = mk(32'h404, 0,0,1,32'h500,0,0,0,0,0,        32'h500,0,1,0,0,0,32'h400);
    vecs[25] = mk(32'h404, 1,0,0,0,1,32'h600,0,0,0,        32'h600,1,1,1,1,0,32'h400);
    vecs[26] = mk(32'h600, 1,1,0,0,0,0,0,0,0,              32'h600,0,0,0,0,0,32'h400);

    Reset = 1'b1;
    drive(32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all("in_reset", RV, 0, 1, 1, 0, 0, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].pc, vecs[i].rdy, vecs[i].stall, vecs[i].jmp, vecs[i].jt, vecs[i].br,
            vecs[i].bt, vecs[i].exc, vecs[i].xpc, vecs[i].eret);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].na, vecs[i].pcw, vecs[i].fif, vecs[i].fid,
                vecs[i].hold, vecs[i].inh, vecs[i].epc);
      @(posedge CLK);
      @(negedge CLK);
    end

    // Reset asserted while a branch is parked: everything clears without a clock edge.
    drive(32'h600, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
    @(posedge CLK);
    @(negedge CLK);
    drive(32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all("hold_before_rst", 32'h300, 0, 1, 0, 1, 0, 32'h400);
    Reset = 1'b1;
    #1;
    check_all("rst_mid_hold", RV, 0, 1, 1, 0, 0, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    drive(32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all("post_rst0", 32'h4, 1, 0, 0, 0, 0, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    CurrentPC = 32'h4;
    #1;
    check_all("post_rst1", 32'h8, 1, 0, 0, 0, 0, 32'h0);
    @(posedge CLK);
    @(negedge CLK);

    // Randomized traffic against the reference model.
    model_reset();
    cur_pc = 32'h8;
    for (int c = 0; c < 400; c++) begin
      Reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) cur_pc = 32'hFFFF_FFFC;
      drive(cur_pc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 5) == 0), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 9) == 0), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 5) == 0));
      #1;
      model_eval();
      check_all($sformatf("rnd%0d", c), e_na, e_pcw, e_fif, e_fid, m_hold, m_inh, m_epc);
      @(posedge CLK);
      m_hold = n_hold; m_inh = n_inh; m_epc = n_epc; m_pend = n_pend; m_pexc = n_pexc;
      if (Reset) cur_pc = RV;
      else if (e_pcw) cur_pc = e_na;
      @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
